// File: rtl/led_sweep_pwm_pkg.sv
// led_sweep_pkg: shared encodings for the LED sweep generator.
//   mode_e : run mode driven on the bus (bounce, wrap, hold, off)
//   dir_e  : sweep direction held by the position FSM
package led_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_sweep_pwm_if.sv
// led_sweep_pwm_if: control and LED-drive bundle of the sweep generator.
//   btn       : pause request, asynchronous to clk
//   mode      : run mode (led_sweep_pkg::mode_e)
//   led       : PWM LED drive, 1 = on
//   sweep_idx : index of the channel currently holding the bright spot
// master = board/bench side, slave = generator side.
interface led_sweep_pwm_if
  import led_sweep_pkg::*;
#(
  parameter int N_LED = 8
);
  localparam int IDX_W = $clog2(N_LED);

  logic             btn;
  mode_e            mode;
  logic [N_LED-1:0] led;
  logic [IDX_W-1:0] sweep_idx;

  modport master (output btn, output mode, input led, input sweep_idx);
  modport slave  (input btn, input mode, output led, output sweep_idx);
endinterface

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED channel. Registers the selected brightness and
// compares it against the shared PWM counter to drive the pin.
//   clk, rst  : clock, async active-high reset
//   bright_in : linear brightness chosen by the top for this channel
//   pwm_ctr   : shared free-running PWM counter
//   led_o     : registered LED drive
// Build option GAMMA_EN: store (b*b)>>PWM_W instead of b, squared in the
// same cycle as the load so the latency does not change.
module led_pwm_chan #(
  parameter int PWM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] bright_in,
  input  logic [PWM_W-1:0] pwm_ctr,
  output logic             led_o
);

  logic [PWM_W-1:0] bright;
  logic [PWM_W-1:0] bright_d;

`ifdef GAMMA_EN
  logic [2*PWM_W-1:0] bright_sq;
  assign bright_sq = bright_in * bright_in;
  assign bright_d  = bright_sq[2*PWM_W-1:PWM_W];
`else
  assign bright_d = bright_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright <= '0;
      led_o  <= 1'b0;
    end else begin
      bright <= bright_d;
      // Strict compare: full scale still leaves one dark slot per period.
      led_o  <= (pwm_ctr < bright);
    end
  end

endmodule

// File: rtl/led_sweep_pwm.sv
// led_sweep_pwm: N-channel LED sweep with linear crossfade and per-channel
// PWM dimming. A position counter (spot index + fraction) steps once per
// 2^PRE_W clocks; the channel under the spot is full scale and its two
// neighbours crossfade with the fraction.
//   clk, rst : clock, async active-high reset
//   bus      : led_sweep_pwm_if.slave (btn, mode in; led, sweep_idx out)
// Build option GAMMA_EN: squared brightness curve inside led_pwm_chan.
//
// state    | meaning
// DIR_UP   | position counts up on each step
// DIR_DOWN | position counts down on each step (BOUNCE only)
module led_sweep_pwm
  import led_sweep_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int PWM_W = 10,
  parameter int PRE_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  led_sweep_pwm_if.slave  bus
);

  localparam int IDX_W = $clog2(N_LED);
  localparam int POS_W = IDX_W + PWM_W;
  localparam logic [PWM_W-1:0] BMAX = '1;
  localparam logic [POS_W-1:0] PMAX = {IDX_W'(N_LED - 1), BMAX};

  logic             btn_meta;
  logic             pause;
  logic [PRE_W-1:0] pre;
  logic [PWM_W-1:0] pwm_ctr;
  logic [POS_W-1:0] pos;
  dir_e             dir;
  logic             step;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] pos_dec;
  logic [IDX_W-1:0] idx;
  logic [PWM_W-1:0] frac;
  logic             is_wrap;
  logic [N_LED-1:0] led_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      pause    <= 1'b0;
      pre      <= '0;
      pwm_ctr  <= '0;
    end else begin
      btn_meta <= bus.btn;
      pause    <= btn_meta;
      pre      <= pre + 1'b1;
      pwm_ctr  <= pwm_ctr + 1'b1;
    end
  end

  assign step = (&pre) && !pause &&
                (bus.mode == MODE_BOUNCE || bus.mode == MODE_WRAP);
  assign pos_inc = pos + 1'b1;
  assign pos_dec = pos - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      dir <= DIR_UP;
    end else if (step) begin
      if (bus.mode == MODE_WRAP) begin
        pos <= (pos == PMAX) ? '0 : pos_inc;
        dir <= DIR_UP;
      end else begin
        case (dir)
          DIR_UP: begin
            // pos can sit at PMAX with dir up after leaving WRAP; turn back.
            if (pos == PMAX) begin
              pos <= pos_dec;
              dir <= DIR_DOWN;
            end else begin
              pos <= pos_inc;
              if (pos_inc == PMAX) dir <= DIR_DOWN;
            end
          end
          default: begin
            if (pos == '0) begin
              pos <= pos_inc;
              dir <= DIR_UP;
            end else begin
              pos <= pos_dec;
              if (pos_dec == '0) dir <= DIR_UP;
            end
          end
        endcase
      end
    end
  end

  assign idx     = pos[POS_W-1:PWM_W];
  assign frac    = pos[PWM_W-1:0];
  assign is_wrap = (bus.mode == MODE_WRAP);

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    localparam logic [IDX_W-1:0] ME   = IDX_W'(i);
    localparam logic [IDX_W-1:0] PREV = IDX_W'((i + N_LED - 1) % N_LED);
    localparam logic [IDX_W-1:0] NEXT = IDX_W'((i + 1) % N_LED);

    logic [PWM_W-1:0] b_lin;

    // PREV/NEXT are modulo N; the end channels only use the wrapped
    // neighbour in WRAP mode.
    always_comb begin
      b_lin = '0;
      if (bus.mode != MODE_OFF) begin
        if (idx == ME)
          b_lin = BMAX;
        else if (idx == PREV && (i > 0 || is_wrap))
          b_lin = frac;
        else if (idx == NEXT && (i < N_LED - 1 || is_wrap))
          b_lin = BMAX - frac;
      end
    end

    led_pwm_chan #(.PWM_W(PWM_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .bright_in (b_lin),
      .pwm_ctr   (pwm_ctr),
      .led_o     (led_w[i])
    );
  end

  assign bus.led       = led_w;
  assign bus.sweep_idx = idx;

endmodule

// File: tb/tb_led_sweep_pwm.sv
// tb_led_sweep_pwm: bench for led_sweep_pwm with N_LED=4, PWM_W=4, PRE_W=2.
// A cycle reference model checks led and sweep_idx on every falling edge;
// table vectors and hand sequences cover the directed corner cases.
module tb_led_sweep_pwm;
  import led_sweep_pkg::*;

  localparam int N_LED   = 4;
  localparam int PWM_W   = 4;
  localparam int PRE_W   = 2;
  localparam int IDX_W   = $clog2(N_LED);
  localparam int BMAX    = (1 << PWM_W) - 1;
  localparam int PMAX    = ((N_LED - 1) << PWM_W) | BMAX;
  localparam int PRE_MAX = (1 << PRE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  led_sweep_pwm_if #(.N_LED(N_LED)) bus ();

  led_sweep_pwm #(.N_LED(N_LED), .PWM_W(PWM_W), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic int gam(int b);
`ifdef GAMMA_EN
    return (b * b) >> PWM_W;
`else
    return b;
`endif
  endfunction

  // Brightness from signed distance between channel and spot; in WRAP the
  // distance is taken around the ring.
  function automatic int lin(int i, int pos, mode_e md);
    int idx;
    int frac;
    int d;
    idx  = pos >> PWM_W;
    frac = pos % (BMAX + 1);
    d    = i - idx;
    if (md == MODE_WRAP && d == N_LED - 1)    d = -1;
    if (md == MODE_WRAP && d == -(N_LED - 1)) d = 1;
    if (md == MODE_OFF) return 0;
    if (d == 0)  return BMAX;
    if (d == 1)  return frac;
    if (d == -1) return BMAX - frac;
    return 0;
  endfunction

  int               m_pos, m_pre, m_pwm;
  bit               m_up, m_s1, m_pause;
  int               m_bright [N_LED];
  bit [N_LED-1:0]   m_led;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_pre = 0; m_pwm = 0;
      m_up = 1'b1; m_s1 = 1'b0; m_pause = 1'b0;
      m_led = '0;
      for (int i = 0; i < N_LED; i++) m_bright[i] = 0;
    end else begin
      bit st;
      for (int i = 0; i < N_LED; i++) m_led[i] = (m_pwm < m_bright[i]);
      for (int i = 0; i < N_LED; i++) m_bright[i] = gam(lin(i, m_pos, bus.mode));
      st = (m_pre == PRE_MAX) && !m_pause &&
           (bus.mode == MODE_BOUNCE || bus.mode == MODE_WRAP);
      if (st) begin
        if (bus.mode == MODE_WRAP) begin
          m_pos = (m_pos + 1) % (PMAX + 1);
          m_up  = 1'b1;
        end else if (m_up) begin
          if (m_pos == PMAX) begin m_pos = m_pos - 1; m_up = 1'b0; end
          else begin m_pos = m_pos + 1; if (m_pos == PMAX) m_up = 1'b0; end
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
          else begin m_pos = m_pos - 1; if (m_pos == 0) m_up = 1'b1; end
        end
      end
      m_pre   = (m_pre + 1) % (PRE_MAX + 1);
      m_pwm   = (m_pwm + 1) % (BMAX + 1);
      m_pause = m_s1;
      m_s1    = bus.btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      checks++;
      if (bus.led !== m_led) begin
        errors++;
        $display("FAIL model_led t=%0t actual=%b required=%b", $time, bus.led, m_led);
      end
      checks++;
      if (bus.sweep_idx !== IDX_W'(m_pos >> PWM_W)) begin
        errors++;
        $display("FAIL model_idx t=%0t actual=%0d required=%0d", $time, bus.sweep_idx, m_pos >> PWM_W);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int duty [N_LED];

  task automatic count_duty(int n);
    for (int i = 0; i < N_LED; i++) duty[i] = 0;
    repeat (n) begin
      tick(1);
      for (int i = 0; i < N_LED; i++) duty[i] += int'(bus.led[i]);
    end
  endtask

  typedef struct {
    mode_e mode;
    int    n_clk;
    int    exp_idx;
    int    exp_led;   // -1: not checked
  } vec_t;

  vec_t vt [13];

  initial begin
    int idx_hold;
    bus.btn  = 1'b0;
    bus.mode = MODE_BOUNCE;
    #1 rst = 1'b1;

    // One step per 4 clocks from pos=0 after reset release.
    vt[0]  = '{MODE_BOUNCE,   0, 0, 0};
    vt[1]  = '{MODE_BOUNCE,   1, 0, 0};
    vt[2]  = '{MODE_BOUNCE,   2, 0, 1};
    vt[3]  = '{MODE_BOUNCE,  64, 1, -1};
    vt[4]  = '{MODE_BOUNCE, 252, 3, -1};
    vt[5]  = '{MODE_BOUNCE, 256, 3, -1};
    vt[6]  = '{MODE_BOUNCE, 440, 1, -1};
    vt[7]  = '{MODE_BOUNCE, 444, 0, -1};
    vt[8]  = '{MODE_BOUNCE, 572, 1, -1};
    vt[9]  = '{MODE_WRAP,   252, 3, -1};
    vt[10] = '{MODE_WRAP,   256, 0, -1};
    vt[11] = '{MODE_HOLD,   300, 0, -1};
    vt[12] = '{MODE_OFF,    300, 0, 0};

    for (int k = 0; k < 13; k++) begin
      bus.mode = vt[k].mode;
      do_reset();
      chk_en = 1'b1;
      tick(vt[k].n_clk);
      check($sformatf("vec%0d_idx", k), int'(bus.sweep_idx), vt[k].exp_idx);
      if (vt[k].exp_led >= 0)
        check($sformatf("vec%0d_led", k), int'(bus.led), vt[k].exp_led);
    end

    // WRAP, pos=53 (idx 3, frac 5) frozen by pause; ch0 is ahead of the spot.
    bus.mode = MODE_WRAP;
    do_reset();
    tick(212);
    bus.btn = 1'b1;
    tick(8);
    check("wrap_idx", int'(bus.sweep_idx), 3);
    count_duty(16);
    check("wrap_ch0", duty[0], gam(5));
    check("wrap_ch1", duty[1], 0);
    check("wrap_ch2", duty[2], gam(10));
    check("wrap_ch3", duty[3], gam(15));
    bus.btn = 1'b0;

    // Pause held 40 clk in BOUNCE at pos=25.
    bus.mode = MODE_BOUNCE;
    do_reset();
    tick(100);
    bus.btn = 1'b1;
    idx_hold = int'(bus.sweep_idx);
    tick(4);
    count_duty(32);
    tick(4);
    check("pause_idx", int'(bus.sweep_idx), idx_hold);
    check("pause_pwm", duty[1], 2 * gam(15));
    bus.btn = 1'b0;
    tick(64);
    check("resume_idx", int'(bus.sweep_idx), 2);

    // HOLD at pos=32: ch2 full, ch1 falling at full, ch0/ch3 dark.
    do_reset();
    tick(128);
    bus.mode = MODE_HOLD;
    tick(4);
    count_duty(32);
    check("hold_ch2", duty[2], 2 * gam(15));
    check("hold_ch1", duty[1], 2 * gam(15));
    check("hold_ch0", duty[0], 0);
    check("hold_ch3", duty[3], 0);
    check("hold_idx", int'(bus.sweep_idx), 2);

    // Async reset mid-clock during the down-sweep.
    bus.mode = MODE_BOUNCE;
    do_reset();
    tick(280);
    check("down_idx", int'(bus.sweep_idx), 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_led", int'(bus.led), 0);
    check("arst_idx", int'(bus.sweep_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(64);
    check("restart_idx", int'(bus.sweep_idx), 1);

    // OFF: LEDs dark within 2 clk, position frozen.
    tick(2);
    bus.mode = MODE_OFF;
    tick(2);
    check("off_led", int'(bus.led), 0);
    idx_hold = int'(bus.sweep_idx);
    count_duty(20);
    check("off_duty0", duty[0] + duty[1] + duty[2] + duty[3], 0);
    check("off_idx", int'(bus.sweep_idx), idx_hold);

    // Randomised modes, pause and occasional reset against the model.
    bus.mode = MODE_BOUNCE;
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      tick(1);
      if ($urandom_range(0, 79) == 0) bus.mode = mode_e'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.btn = ~bus.btn;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
